// File: rtl/warp_rr_arbiter.sv
// Round-robin warp issue arbiter: valid/ready handshake with stall-stable grants
// and bounded grant locking. Optional priority masking under `WARP_ARB_PRIO_EN.
module warp_rr_arbiter #(
  parameter int NUM_REQ  = 4,  // NUM_WARPS_PER_SM
  parameter int MAX_HOLD = 4,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] request,
  input  logic [NUM_REQ-1:0] lock,
`ifdef WARP_ARB_PRIO_EN
  input  logic [NUM_REQ-1:0] prio,
`endif
  input  logic               grant_ready,
  output logic               grant_valid,
  output logic [NUM_REQ-1:0] grantOH,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               locked
);

  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);
  localparam logic [IDX_W:0]    NUM_REQ_C  = (IDX_W + 1)'(NUM_REQ);
  localparam logic [IDX_W-1:0]  LAST_RST_C = IDX_W'(NUM_REQ - 1);
  localparam bit                LOCK_EN    = (MAX_HOLD > 1);

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t              state_r;
  logic [IDX_W-1:0]    last_ptr_r;
  logic [IDX_W-1:0]    owner_r;
  logic [HOLD_W-1:0]   hold_cnt_r;
  logic                pend_valid_r;
  logic [IDX_W-1:0]    pend_idx_r;

  logic [NUM_REQ-1:0]  req_eff_s;
  logic [IDX_W:0]      cand_s;
  logic                rr_found_s;
  logic [IDX_W-1:0]    rr_idx_s;
  logic                pend_hit_s;
  logic                lock_hit_s;
  logic                sel_valid_s;
  logic [IDX_W-1:0]    sel_idx_s;
  logic                accept_s;
  logic                stall_s;
  logic [HOLD_W-1:0]   hold_inc_s;

  // Search mask: priority requesters win the round-robin when any are present.
  always_comb begin
    req_eff_s = request;
`ifdef WARP_ARB_PRIO_EN
    if ((request & prio) != {NUM_REQ{1'b0}}) begin
      req_eff_s = request & prio;
    end else begin
      req_eff_s = request;
    end
`endif
  end

  // Round-robin search starting just after last_ptr, wrapping, last_ptr checked last.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = {IDX_W{1'b0}};
    cand_s     = {(IDX_W + 1){1'b0}};
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand_s     = {1'b0, last_ptr_r} + (IDX_W + 1)'(k);
      cand_s     = (cand_s >= NUM_REQ_C) ? (cand_s - NUM_REQ_C) : cand_s;
      rr_idx_s   = (!rr_found_s && req_eff_s[cand_s[IDX_W-1:0]]) ? cand_s[IDX_W-1:0] : rr_idx_s;
      rr_found_s = rr_found_s | req_eff_s[cand_s[IDX_W-1:0]];
    end
  end

  assign pend_hit_s = pend_valid_r & request[pend_idx_r];
  assign lock_hit_s = (state_r == ST_LOCKED) & request[owner_r];

  // Grant selection: stalled grant, then locked owner, then round-robin.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_idx_s   = {IDX_W{1'b0}};
    if (pend_hit_s) begin
      sel_valid_s = 1'b1;
      sel_idx_s   = pend_idx_r;
    end else if (lock_hit_s) begin
      sel_valid_s = 1'b1;
      sel_idx_s   = owner_r;
    end else begin
      sel_valid_s = rr_found_s;
      sel_idx_s   = rr_found_s ? rr_idx_s : {IDX_W{1'b0}};
    end
  end

  assign grant_valid = ~reset & sel_valid_s;
  assign grant_idx   = grant_valid ? sel_idx_s : {IDX_W{1'b0}};
  assign grantOH     = {{(NUM_REQ - 1){1'b0}}, grant_valid} << grant_idx;
  assign locked      = ~reset & (state_r == ST_LOCKED);

  assign accept_s   = grant_valid & grant_ready;
  assign stall_s    = grant_valid & ~grant_ready;
  assign hold_inc_s = hold_cnt_r + HOLD_W'(1);

  // Arbitration state: round-robin pointer, stall memory and lock tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_ARB;
      last_ptr_r   <= LAST_RST_C;
      owner_r      <= {IDX_W{1'b0}};
      hold_cnt_r   <= {HOLD_W{1'b0}};
      pend_valid_r <= 1'b0;
      pend_idx_r   <= {IDX_W{1'b0}};
    end else begin
      if (accept_s) begin
        last_ptr_r   <= grant_idx;
        pend_valid_r <= 1'b0;
      end else if (stall_s) begin
        pend_valid_r <= 1'b1;
        pend_idx_r   <= grant_idx;
      end else begin
        pend_valid_r <= 1'b0;
      end

      case (state_r)
        ST_ARB: begin
          if (LOCK_EN && accept_s && lock[grant_idx]) begin
            state_r    <= ST_LOCKED;
            owner_r    <= grant_idx;
            hold_cnt_r <= HOLD_W'(1);
          end else begin
            hold_cnt_r <= {HOLD_W{1'b0}};
          end
        end
        ST_LOCKED: begin
          // Owner dropping its request ends the burst at once.
          if (!request[owner_r]) begin
            state_r    <= ST_ARB;
            hold_cnt_r <= {HOLD_W{1'b0}};
          end else if (accept_s && (grant_idx == owner_r)) begin
            if ((hold_inc_s == MAX_HOLD_C) || !lock[owner_r]) begin
              state_r    <= ST_ARB;
              hold_cnt_r <= {HOLD_W{1'b0}};
            end else begin
              hold_cnt_r <= hold_inc_s;
            end
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        default: begin
          state_r    <= ST_ARB;
          hold_cnt_r <= {HOLD_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_warp_rr_arbiter.sv
// Directed self-checking bench for warp_rr_arbiter (NUM_REQ=4, MAX_HOLD=4).
module tb_warp_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] request;
  logic [3:0] lock;
  logic       grant_ready;
  logic       grant_valid;
  logic [3:0] grantOH;
  logic [1:0] grant_idx;
  logic       locked;

  int errors = 0;
  int checks = 0;

  int exp5_idx [8] = '{0, 0, 0, 0, 1, 2, 3, 0};
  int exp5_lock[8] = '{0, 1, 1, 1, 0, 0, 0, 0};

  warp_rr_arbiter #(.NUM_REQ(4), .MAX_HOLD(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .request     (request),
    .lock        (lock),
    .grant_ready (grant_ready),
    .grant_valid (grant_valid),
    .grantOH     (grantOH),
    .grant_idx   (grant_idx),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check a full grant: valid, index and matching one-hot.
  task automatic chk_grant(input string tag, input int idx);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    chk({tag, ".valid"}, {31'd0, grant_valid}, 32'd1);
    chk({tag, ".idx"},   {30'd0, grant_idx},   idx);
    chk({tag, ".oh"},    {28'd0, grantOH},     {28'd0, oh});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".valid"}, {31'd0, grant_valid}, 32'd0);
    chk({tag, ".idx"},   {30'd0, grant_idx},   32'd0);
    chk({tag, ".oh"},    {28'd0, grantOH},     32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; request = 4'b0000; lock = 4'b0000; grant_ready = 1'b0;
    tick(); tick();

    // Reset: outputs forced low even with requests present
    request = 4'b1111; grant_ready = 1'b1; #2;
    chk_idle("rst");
    chk("rst.locked", {31'd0, locked}, 32'd0);
    tick();
    reset = 1'b0;

    // T1: full rotation
    for (int i = 0; i < 8; i++) begin
      #2; chk_grant($sformatf("t1.c%0d", i), i % 4);
      tick();
    end

    // T2: sparse requesters then idle
    pulse_reset();
    request = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      #2; chk_grant($sformatf("t2.c%0d", i), (i % 2 == 0) ? 1 : 3);
      tick();
    end
    request = 4'b0000; #2;
    chk_idle("t2.idle");
    tick();

    // T3: stalled grant held, even when the search would move elsewhere
    pulse_reset();
    request = 4'b0110; grant_ready = 1'b0;
    #2; chk_grant("t3.s0", 1); tick();
    request = 4'b0111;
    #2; chk_grant("t3.s1", 1); tick();
    #2; chk_grant("t3.s2", 1); tick();
    request = 4'b0110; grant_ready = 1'b1;
    #2; chk_grant("t3.acc", 1); tick();
    #2; chk_grant("t3.next", 2); tick();

    // T4: withdrawal of a stalled request re-arbitrates in the same cycle
    pulse_reset();
    request = 4'b0110; grant_ready = 1'b0;
    #2; chk_grant("t4.stall", 1); tick();
    request = 4'b0100; grant_ready = 1'b1;
    #2; chk_grant("t4.wd", 2); tick();
    request = 4'b1110;
    #2; chk_grant("t4.after", 3); tick();

    // T5: bounded lock on warp 0
    pulse_reset();
    request = 4'b1111; lock = 4'b0001; grant_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk_grant($sformatf("t5.c%0d", i), exp5_idx[i]);
      chk($sformatf("t5.lk%0d", i), {31'd0, locked}, exp5_lock[i]);
      tick();
    end

    // T6: reset mid-lock (hold count 2)
    #2; chk_grant("t6.pre", 0); chk("t6.pre.lk", {31'd0, locked}, 32'd1); tick();
    reset = 1'b1; #2;
    chk_idle("t6.rst");
    chk("t6.rst.lk", {31'd0, locked}, 32'd0);
    tick();
    reset = 1'b0; lock = 4'b0000;
    #2; chk_grant("t6.g0", 0); chk("t6.g0.lk", {31'd0, locked}, 32'd0); tick();
    #2; chk_grant("t6.g1", 1); tick();

    // T7: lock released early when the owner's lock bit drops
    pulse_reset();
    lock = 4'b0001;
    #2; chk_grant("t7.c0", 0); tick();
    lock = 4'b0000;
    #2; chk_grant("t7.c1", 0); chk("t7.c1.lk", {31'd0, locked}, 32'd1); tick();
    #2; chk_grant("t7.c2", 1); chk("t7.c2.lk", {31'd0, locked}, 32'd0); tick();

    // T8: lock released when the owner stops requesting
    pulse_reset();
    lock = 4'b0001;
    #2; chk_grant("t8.c0", 0); tick();
    request = 4'b1110; lock = 4'b0000;
    #2; chk_grant("t8.c1", 1); tick();
    #2; chk("t8.c2.lk", {31'd0, locked}, 32'd0); chk_grant("t8.c2", 2); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
